// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: types and constants shared by the next-PC sequencer and its return stack.
//   seq_state_t  - lifecycle states of the sequencer
//   *_DEFAULT    - default parameter values for PC width, branch offset width and stack depth
//   PRIO_*       - control-flow request codes; a lower code wins when several requests coincide
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam int D_DEFAULT     = 10;
    localparam int OFF_W_DEFAULT = 6;
    localparam int DEPTH_DEFAULT = 4;

    // Request priority: halt > return > call > jump > taken branch > nothing.
    localparam logic [2:0] PRIO_HALT = 3'd0;
    localparam logic [2:0] PRIO_RET  = 3'd1;
    localparam logic [2:0] PRIO_CALL = 3'd2;
    localparam logic [2:0] PRIO_JMP  = 3'd3;
    localparam logic [2:0] PRIO_BR   = 3'd4;
    localparam logic [2:0] PRIO_NONE = 3'd5;

endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses for call/return.
//   clk, reset   - clock, asynchronous active-high reset (empties stack, zeroes contents)
//   clear        - synchronous clear (same effect as reset, on the clock edge)
//   push, data   - push data when not full (ignored when full)
//   pop          - discard top entry when not empty (ignored when empty)
//   top          - most recently pushed entry (meaningless while empty)
//   full, empty  - occupancy flags
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int D     = D_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] data,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [D-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q;

    // Storage and occupancy count; count_q doubles as the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[count_q[AW-1:0]] <= data;
            count_q                <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == CW'(0));
    assign top   = mem_q[AW'(count_q - CW'(1))];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller. Chooses whether the PC loads a target or increments,
// from decoded halt/return/call/jump/branch requests, and owns the IDLE/RUN/HALT lifecycle.
//   clk, reset             - clock, asynchronous active-high reset
//   start                  - leave IDLE/HALT; first fetch is address 0
//   prog_ctr               - current PC
//   br_en, cond, offset    - conditional relative branch (signed offset)
//   jmp_en, call_en        - absolute jump / call to abs_target
//   ret_en                 - return to top of return stack
//   halt_in                - halt instruction
//   jump_en, target        - PC load request and value (combinational, applied next edge)
//   running, done          - state is RUN / HALT
//   stack_err              - sticky stack overflow/underflow
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D     = D_DEFAULT,
    parameter int OFF_W = OFF_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [D-1:0]     prog_ctr,
    input  logic             br_en,
    input  logic             cond,
    input  logic [OFF_W-1:0] offset,
    input  logic             jmp_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [D-1:0]     abs_target,
    input  logic             halt_in,
    output logic             jump_en,
    output logic [D-1:0]     target,
    output logic             running,
    output logic             done,
    output logic             stack_err
);

    seq_state_t   state_q, state_d;
    logic         err_q, err_d;
    logic [2:0]   req_sel_s;
    logic         push_s, pop_s, clear_s;
    logic [D-1:0] ret_addr_s, br_target_s, stack_top_s;
    logic         stack_full_s, stack_empty_s;
    logic         jump_en_s;
    logic [D-1:0] target_s;

    assign ret_addr_s  = prog_ctr + D'(1);
    assign br_target_s = prog_ctr + {{(D - OFF_W){offset[OFF_W-1]}}, offset};

    return_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .push  (push_s),
        .pop   (pop_s),
        .data  (ret_addr_s),
        .top   (stack_top_s),
        .full  (stack_full_s),
        .empty (stack_empty_s)
    );

    // Priority encoder over the decoded control-flow requests.
    always_comb begin
        req_sel_s = PRIO_NONE;
        if (halt_in) begin
            req_sel_s = PRIO_HALT;
        end else if (ret_en) begin
            req_sel_s = PRIO_RET;
        end else if (call_en) begin
            req_sel_s = PRIO_CALL;
        end else if (jmp_en) begin
            req_sel_s = PRIO_JMP;
        end else if (br_en && cond) begin
            req_sel_s = PRIO_BR;
        end else begin
            req_sel_s = PRIO_NONE;
        end
    end

    // Next-state, target mux and stack control. Default is "hold the PC".
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        jump_en_s = 1'b1;
        target_s  = prog_ctr;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        clear_s   = 1'b0;
        if (reset) begin
            // While reset is held the PC is frozen regardless of start.
            jump_en_s = 1'b1;
            target_s  = prog_ctr;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_s = '0;
                        state_d  = RUN;
                    end else begin
                        target_s = prog_ctr;
                    end
                end
                RUN: begin
                    case (req_sel_s)
                        PRIO_HALT: state_d = HALT;
                        PRIO_RET: begin
                            if (stack_empty_s) begin
                                jump_en_s = 1'b0;
                                err_d     = 1'b1;
                            end else begin
                                target_s = stack_top_s;
                                pop_s    = 1'b1;
                            end
                        end
                        PRIO_CALL: begin
                            target_s = abs_target;
                            if (stack_full_s) begin
                                err_d = 1'b1;
                            end else begin
                                push_s = 1'b1;
                            end
                        end
                        PRIO_JMP: target_s  = abs_target;
                        PRIO_BR:  target_s  = br_target_s;
                        default:  jump_en_s = 1'b0;
                    endcase
                end
                HALT: begin
                    if (start) begin
                        target_s = '0;
                        state_d  = RUN;
                        clear_s  = 1'b1;
                        err_d    = 1'b0;
                    end else begin
                        target_s = prog_ctr;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Lifecycle state and sticky stack error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign jump_en   = jump_en_s;
    assign target    = target_s;
    assign running   = (state_q == RUN);
    assign done      = (state_q == HALT);
    assign stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] prog_ctr;
    logic       br_en, cond, jmp_en, call_en, ret_en, halt_in;
    logic [5:0] offset;
    logic [9:0] abs_target;
    logic       jump_en, running, done, stack_err;
    logic [9:0] target;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_ctr   (prog_ctr),
        .br_en      (br_en),
        .cond       (cond),
        .offset     (offset),
        .jmp_en     (jmp_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .abs_target (abs_target),
        .halt_in    (halt_in),
        .jump_en    (jump_en),
        .target     (target),
        .running    (running),
        .done       (done),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, br, cond, jmp, call, ret, halt;
        logic [9:0] pc, abs;
        logic [5:0] off;
    } stim_t;

    typedef struct {
        logic       jump_en, running, done, err;
        logic [9:0] target;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_HALT} mstate_e;

    int      checks = 0;
    int      errors = 0;
    exp_t    exp_q[$];
    mstate_e m_state;
    logic [9:0] m_stack[$];
    bit      m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    // Reference behaviour: one cycle of the sequencer expressed over a queue-based stack.
    task automatic model_step(input stim_t s, output exp_t e);
        int t;
        logic [9:0] ra;
        e.running = (m_state == M_RUN);
        e.done    = (m_state == M_HALT);
        e.err     = m_err;
        e.jump_en = 1'b1;
        e.target  = s.pc;
        if (m_state == M_IDLE) begin
            if (s.start) begin e.target = 10'd0; m_state = M_RUN; end
        end else if (m_state == M_HALT) begin
            if (s.start) begin
                e.target = 10'd0; m_state = M_RUN; m_stack.delete(); m_err = 1'b0;
            end
        end else begin
            if (s.halt) begin
                m_state = M_HALT;
            end else if (s.ret) begin
                if (m_stack.size() > 0) e.target = m_stack.pop_back();
                else begin e.jump_en = 1'b0; m_err = 1'b1; end
            end else if (s.call) begin
                e.target = s.abs;
                ra = s.pc + 10'd1;
                if (m_stack.size() == 4) m_err = 1'b1;
                else m_stack.push_back(ra);
            end else if (s.jmp) begin
                e.target = s.abs;
            end else if (s.br && s.cond) begin
                t = int'(s.pc) + int'($signed(s.off));
                e.target = t[9:0];
            end else begin
                e.jump_en = 1'b0;
            end
        end
    endtask

    task automatic apply(input stim_t s);
        start = s.start; prog_ctr = s.pc; br_en = s.br; cond = s.cond; offset = s.off;
        jmp_en = s.jmp; call_en = s.call; ret_en = s.ret; abs_target = s.abs; halt_in = s.halt;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        model_step(s, e);
        exp_q.push_back(e);
    endtask

    function automatic stim_t nop(input logic [9:0] pc);
        stim_t s;
        s = '{default: '0};
        s.pc = pc;
        return s;
    endfunction

    // Monitor: compares the pending expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("running", 32'(running), 32'(e.running));
            chk("done", 32'(done), 32'(e.done));
            chk("stack_err", 32'(stack_err), 32'(e.err));
            chk("jump_en", 32'(jump_en), 32'(e.jump_en));
            if (e.jump_en) chk("target", 32'(target), 32'(e.target));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int wait_cycles;
        model_reset();
        apply(nop(10'h015));
        start = 1'b1;
        reset = 1'b1;
        #3;
        chk("rst_jump_en", 32'(jump_en), 32'd1);
        chk("rst_target", 32'(target), 32'h15);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(stack_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        // Start from IDLE at PC 0x15.
        drive(nop(10'h015));
        s = nop(10'h015); s.start = 1'b1; drive(s);
        drive(nop(10'h000));
        // Branch with wrap-around, taken and not taken.
        s = nop(10'h003); s.br = 1'b1; s.cond = 1'b1; s.off = 6'b111100; drive(s);
        s.cond = 1'b0; drive(s);
        // Call then return.
        s = nop(10'h010); s.call = 1'b1; s.abs = 10'h200; drive(s);
        drive(nop(10'h200));
        s = nop(10'h201); s.ret = 1'b1; drive(s);
        // Five nested calls, five returns.
        for (int i = 0; i < 5; i++) begin
            s = nop(10'(10'h100 + i)); s.call = 1'b1; s.abs = 10'(10'h300 + i); drive(s);
        end
        for (int i = 0; i < 5; i++) begin
            s = nop(10'h3F0); s.ret = 1'b1; drive(s);
        end
        drive(nop(10'h001));
        // Halt beats call; restart clears stack and error.
        s = nop(10'h123); s.halt = 1'b1; s.call = 1'b1; s.abs = 10'h0AA; drive(s);
        drive(nop(10'h123));
        s = nop(10'h123); s.start = 1'b1; drive(s);
        drive(nop(10'h000));
        s = nop(10'h000); s.ret = 1'b1; drive(s);
        s = nop(10'h111); s.halt = 1'b1; drive(s);
        s = nop(10'h111); s.start = 1'b1; drive(s);
        s = nop(10'h020); s.call = 1'b1; s.abs = 10'h040; drive(s);
        s = nop(10'h040); s.call = 1'b1; s.abs = 10'h060; drive(s);

        // Asynchronous reset between edges with two entries stacked.
        @(posedge clk);
        #1;
        apply(nop(10'h055));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_jump_en", 32'(jump_en), 32'd1);
        chk("arst_target", 32'(target), 32'h55);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        s = nop(10'h055); s.start = 1'b1; drive(s);
        s = nop(10'h000); s.ret = 1'b1; drive(s);
        drive(nop(10'h001));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            s.start = ($urandom_range(0, 7) == 0);
            s.halt  = ($urandom_range(0, 39) == 0);
            s.ret   = ($urandom_range(0, 4) == 0);
            s.call  = ($urandom_range(0, 4) == 0);
            s.jmp   = ($urandom_range(0, 7) == 0);
            s.br    = ($urandom_range(0, 2) == 0);
            s.cond  = 1'($urandom);
            s.pc    = 10'($urandom);
            s.abs   = 10'($urandom);
            s.off   = 6'($urandom);
            drive(s);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
